// File: rtl/div_issue_ctrl.sv
// Execute-stage issue controller for the iterative 32-bit divider: latches DIV/DIVU operands,
// runs the start/annul handshake, stalls EX until ready and emits a one-cycle HI/LO write.
// Optional feature: define DIV_ZERO_TRAP_EN to trap zero divisors instead of issuing them.
module div_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  op_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [4:0]  div_op_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        hi_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_zero_exc_o,
  output logic [1:0]  dbg_state_o
);

  // Control codes, kept in step with alu_defines.vh.
  localparam logic [4:0] DIV_CONTROL  = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL = 5'b11011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Handshake: the divider runs while div_start_o is high and raises div_ready_i when done,
  // holding it until start drops; div_annul_o is a single-cycle abort that always comes with
  // start falling on the next edge. hi_we_o is the only result qualifier; hi_o/lo_o are 0 otherwise.

  state_t      state_q, state_d;
  logic        start_q, start_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;

  logic is_div;
  logic req;
  logic zero_trap;
  logic stall;
  logic annul;
  logic we;
  logic exc;

  always_comb begin
    is_div = (op_i == DIV_CONTROL) || (op_i == DIVU_CONTROL);
    req    = valid_i & is_div & ~flush_i;
`ifdef DIV_ZERO_TRAP_EN
    zero_trap = req & (opdata2_i == 32'd0);
`else
    zero_trap = 1'b0;
`endif

    state_d = state_q;
    start_d = start_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    stall   = 1'b0;
    annul   = 1'b0;
    we      = 1'b0;
    exc     = 1'b0;

    case (state_q)
      IDLE: begin
        stall = req & ~zero_trap;
        exc   = zero_trap;
        if (req && !zero_trap) begin
          op_d    = op_i;
          a_d     = opdata1_i;
          b_d     = opdata2_i;
          start_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Flush takes priority so an annulled run never writes HI/LO.
        if (flush_i) begin
          annul   = 1'b1;
          start_d = 1'b0;
          state_d = DRAIN;
        end else if (div_ready_i) begin
          we      = 1'b1;
          start_d = 1'b0;
          state_d = DRAIN;
        end else begin
          stall = 1'b1;
        end
      end
      DRAIN: begin
        // One cycle with start low lets the divider fall back to its free state.
        stall   = req;
        start_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      op_q    <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign stall_o        = stall;
  assign div_annul_o    = annul;
  assign hi_we_o        = we;
  assign div_zero_exc_o = exc;
  assign div_start_o    = start_q;
  assign div_op_o       = op_q;
  assign div_opdata1_o  = a_q;
  assign div_opdata2_o  = b_q;
  assign hi_o           = we ? div_result_i[63:32] : 32'd0;
  assign lo_o           = we ? div_result_i[31:0]  : 32'd0;
  assign dbg_state_o    = state_q;

endmodule
